// File: rtl/alu_cmd_issuer_if.sv
// Handshake and ALU drive bundle for alu_cmd_issuer.
// Halt-mode signals exist only when ALU_CMD_HALT_EN is defined.
// master = command source / ALU side, slave = the issuer itself.
interface alu_cmd_issuer_if #(
    parameter int N     = 16,
    parameter int DEPTH = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [3:0]                cmd_op;
    logic [N-1:0]              cmd_data;
    logic [13:0]               buttons;
    logic [N-1:0]              bus_in;
    logic                      busy;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      cmd_err;
`ifdef ALU_CMD_HALT_EN
    logic [2:0]                alu_error;
    logic                      resume;
    logic                      halted;

    modport master (
        output cmd_valid, cmd_op, cmd_data, alu_error, resume,
        input  cmd_ready, buttons, bus_in, busy, fifo_count, cmd_err, halted
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, alu_error, resume,
        output cmd_ready, buttons, bus_in, busy, fifo_count, cmd_err, halted
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, buttons, bus_in, busy, fifo_count, cmd_err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, buttons, bus_in, busy, fifo_count, cmd_err
    );
`endif
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 16-bit ALU: FIFO-buffered opcodes turned into one-hot button pulses.
// Optional halt-on-ALU-error behaviour is enabled by defining ALU_CMD_HALT_EN.
// Contains the generic command FIFO and the issuer top.

// Generic synchronous FIFO, registered count, read data taken from the head slot.
// Latency: a push on edge k is visible at pop_dat / count after edge k.
// Backpressure: caller must not push when full nor pop when empty; full/empty come from registers.
module alu_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign count   = cnt_q;
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
endmodule

// Issues queued ALU opcodes as single-cycle one-hot pulses followed by GAP idle cycles.
// Latency: command accepted on edge k into an empty FIFO pulses buttons from edge k+1 to k+2.
// Backpressure: cmd_ready = FIFO not full (registered count only); illegal ops handshake and are dropped.
module alu_cmd_issuer #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_issuer_if.slave   io
);
    typedef struct packed {
        logic [3:0]   op;
        logic [N-1:0] data;
    } cmd_t;

    localparam logic [3:0] OP_LDA = 4'd8;
    localparam logic [3:0] OP_LDB = 4'd9;

`ifdef ALU_CMD_HALT_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
`endif

    state_t       state;
    logic [3:0]   gap_cnt;
    logic [13:0]  buttons_q;
    logic [N-1:0] bus_in_q;
    logic         cmd_err_q;

    cmd_t         push_cmd;
    cmd_t         head;
    logic         op_legal;
    logic         handshake;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;

    function automatic logic [13:0] op_onehot(input logic [3:0] op);
        op_onehot = 14'(1) << (op - 4'd1);
    endfunction

    assign op_legal      = (io.cmd_op != 4'd0) && (io.cmd_op != 4'd15);
    assign handshake     = io.cmd_valid && io.cmd_ready;
    assign fifo_push     = handshake && op_legal;
    assign fifo_pop      = (state == S_IDLE) && !fifo_empty;
    assign push_cmd.op   = io.cmd_op;
    assign push_cmd.data = io.cmd_data;

    alu_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .count    (io.fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign io.cmd_ready = !fifo_full;
    assign io.busy      = !fifo_empty || (state != S_IDLE);
    assign io.buttons   = buttons_q;
    assign io.bus_in    = bus_in_q;
    assign io.cmd_err   = cmd_err_q;

    // Flag a dropped illegal opcode for exactly one cycle after its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmd_err_q <= 1'b0;
        else     cmd_err_q <= handshake && !op_legal;
    end

`ifdef ALU_CMD_HALT_EN
    logic halted_q;
    logic arith_q;     // last issued op was +, - or x
    logic gap_first;   // currently in the first GAP cycle
    assign io.halted = halted_q;

    // Issue sequencer: pop in IDLE, pulse in ISSUE, hold zero in GAP, park in HALT on ALU error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            buttons_q <= '0;
            bus_in_q  <= '0;
            halted_q  <= 1'b0;
            arith_q   <= 1'b0;
            gap_first <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        buttons_q <= op_onehot(head.op);
                        if (head.op == OP_LDA || head.op == OP_LDB) bus_in_q <= head.data;
                        arith_q   <= (head.op <= 4'd3);
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    buttons_q <= '0;
                    gap_cnt   <= 4'(GAP - 1);
                    gap_first <= 1'b1;
                    state     <= S_GAP;
                end
                S_GAP: begin
                    gap_first <= 1'b0;
                    if (gap_first && arith_q && (io.alu_error != 3'b000)) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else if (gap_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_HALT: begin
                    if (io.resume) begin
                        halted_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    // Issue sequencer: pop in IDLE, pulse in ISSUE, hold zero in GAP until the counter expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            buttons_q <= '0;
            bus_in_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        buttons_q <= op_onehot(head.op);
                        if (head.op == OP_LDA || head.op == OP_LDB) bus_in_q <= head.data;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    buttons_q <= '0;
                    gap_cnt   <= 4'(GAP - 1);
                    state     <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) state <= S_IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif
endmodule
